uart_tx_param: RTL

Parametrised UART transmitter: serialises one data word per valid/ready handshake into a start bit, DBITS data bits (LSB first), an optional parity bit and one or two stop bits on `txd`. It sits between the host-side register/FIFO logic and the pad, and is timed by the shared oversampling strobe `baudx16_en` from the baud generator. It supersedes the fixed 8N1 transmitter with per-frame parity and stop-bit selection, a ready/valid handshake, and configurable data width and oversampling ratio.

---
 rtl/uart_tx_if.sv | 21 ++
 rtl/uart_tx_param.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/uart_tx_if.sv
// Word handshake between the host-side logic and the UART transmitter.
// Ports: tx_valid/tx_data from the host (master), tx_ready from the transmitter (slave).
interface uart_tx_if #(
    parameter int DBITS = 8
);
    logic             tx_valid;
    logic             tx_ready;
    logic [DBITS-1:0] tx_data;

    modport master (
        output tx_valid,
        output tx_data,
        input  tx_ready
    );

    modport slave (
        input  tx_valid,
        input  tx_data,
        output tx_ready
    );
endinterface

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start, DBITS data (LSB first), optional parity, 1/2 stop bits.
// Ports: sysclk, rst (sync, active high), baudx16_en strobe, parity_mode, stop2,
//        tx (uart_tx_if.slave: tx_valid/tx_ready/tx_data), txd, tx_busy,
//        break_req (only when UART_TX_BREAK_EN is defined).
module uart_tx_param #(
    parameter int DBITS      = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic       sysclk,
    input  logic       rst,
    input  logic       baudx16_en,
    input  logic [1:0] parity_mode,
    input  logic       stop2,
`ifdef UART_TX_BREAK_EN
    input  logic       break_req,
`endif
    uart_tx_if.slave   tx,
    output logic       txd,
    output logic       tx_busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = 4;
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DBITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK,
        S_BRKREC
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [TW-1:0]    tick_cnt;
    logic [BW-1:0]    bit_cnt;
    logic [DBITS-1:0] shreg;
    logic             par_bit;
    logic             par_en;
    logic             two_stop;
    logic             txd_n;
    logic             busy_n;
    logic             tick_done;
    logic             accept;

    assign tick_done = baudx16_en && (tick_cnt == TICK_LAST);

`ifdef UART_TX_BREAK_EN
    // A pending break blocks the handshake so break always wins in IDLE.
    assign tx.tx_ready = (state == S_IDLE) & ~rst & ~break_req;
`else
    assign tx.tx_ready = (state == S_IDLE) & ~rst;
`endif

    assign accept = tx.tx_valid & tx.tx_ready;

    // State register; txd/tx_busy are registered from the next-state outputs.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            state   <= S_IDLE;
            txd     <= 1'b1;
            tx_busy <= 1'b0;
        end else begin
            state   <= state_n;
            txd     <= txd_n;
            tx_busy <= busy_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE: begin
`ifdef UART_TX_BREAK_EN
                if (break_req)
                    state_n = S_BREAK;
                else if (accept)
                    state_n = S_START;
`else
                if (accept)
                    state_n = S_START;
`endif
            end
            S_START: begin
                if (tick_done)
                    state_n = S_DATA;
            end
            S_DATA: begin
                if (tick_done && bit_cnt == DATA_LAST)
                    state_n = par_en ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                if (tick_done)
                    state_n = S_STOP;
            end
            S_STOP: begin
                if (tick_done && (!two_stop || bit_cnt == BW'(1)))
                    state_n = S_IDLE;
            end
`ifdef UART_TX_BREAK_EN
            S_BREAK: begin
                if (!break_req)
                    state_n = S_BRKREC;
            end
            S_BRKREC: begin
                if (tick_done)
                    state_n = S_IDLE;
            end
`endif
            default: state_n = S_IDLE;
        endcase
    end

    // Output logic, evaluated for the state being entered.
    always_comb begin
        txd_n  = 1'b1;
        busy_n = (state_n != S_IDLE);
        unique case (state_n)
            S_START:  txd_n = 1'b0;
            // On a data bit boundary the register shifts this edge, so look one bit ahead.
            S_DATA:   txd_n = (state == S_DATA && tick_done) ? shreg[1] : shreg[0];
            S_PARITY: txd_n = par_bit;
            S_BREAK:  txd_n = 1'b0;
            default:  txd_n = 1'b1;
        endcase
    end

    // Datapath: frame latch, shift register and bit-timing counters.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            par_en   <= 1'b0;
            two_stop <= 1'b0;
        end else begin
            if (accept) begin
                shreg    <= tx.tx_data;
                // 01 odd, 10 even: enabled exactly when the two bits differ.
                par_en   <= ^parity_mode;
                par_bit  <= parity_mode[0] ? ~^tx.tx_data : ^tx.tx_data;
                two_stop <= stop2;
            end else if (state == S_DATA && tick_done) begin
                shreg <= shreg >> 1;
            end

            // Every state entry starts a fresh bit time.
            if (state == S_IDLE || state_n != state || tick_done)
                tick_cnt <= '0;
            else if (baudx16_en)
                tick_cnt <= tick_cnt + 1'b1;

            if (state_n != state)
                bit_cnt <= '0;
            else if (tick_done)
                bit_cnt <= bit_cnt + 1'b1;
        end
    end

endmodule
